// File: rtl/virgule_pkg.sv
// Shared Virgule SoC bus types and constants.
// Holds the word-bus typedefs, the bus error word and the interconnect state encoding.
package virgule_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  wstrobe_t;

  localparam word_t BUS_ERROR_WORD = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DECERR
  } bus_ic_state_t;

endpackage

// File: rtl/bus_decoder.sv
// Combinational address decoder: picks the slave whose base/mask window matches the address.
// Overlapping windows resolve to the lowest slave index.
module bus_decoder
  import virgule_pkg::*;
#(
  parameter int                       NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0,
  localparam int                      IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  word_t           address,
  output logic            hit,
  output logic [IW-1:0]   index
);

  // Scanning from the top down lets the lowest matching index overwrite the others.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((address & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit   = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// 1-master to NUM_SLAVES-slave valid/ready crossbar with built-in decode-error responder and IRQ merge.
// Define BUS_INTERCONNECT_TIMEOUT_EN to abort slave accesses that stall for TIMEOUT_CYCLES cycles.
module bus_interconnect
  import virgule_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {32'h3000_0000, 32'h2000_0000,
                                                        32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {4{32'hF000_0000}},
  parameter int                       TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  word_t                    m_address,
  input  wstrobe_t                 m_wstrobe,
  input  word_t                    m_wdata,
  output word_t                    m_rdata,
  output logic                     m_irq,
  output logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  output word_t                    s_address,
  output wstrobe_t                 s_wstrobe,
  output word_t                    s_wdata,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_irq,
  output logic                     err
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  generate
    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("bus_interconnect: NUM_SLAVES must be 1..16 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  bus_ic_state_t   state;
  logic [IW-1:0]   sel;
  logic            dec_hit;
  logic [IW-1:0]   dec_index;
  logic            ready_sel;
  word_t           rdata_sel;
  logic            abort;

  assign s_address = m_address;
  assign s_wstrobe = m_wstrobe;
  assign s_wdata   = m_wdata;

  bus_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .address (m_address),
    .hit     (dec_hit),
    .index   (dec_index)
  );

  always_comb begin
    ready_sel = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == IW'(i)) begin
        ready_sel = s_ready[i];
        rdata_sel = s_rdata[32*i +: 32];
      end
    end
  end

`ifdef BUS_INTERCONNECT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;

  // A slave that answers in the terminal cycle still completes normally.
  assign abort = (state == ACCESS) && (timer == TW'(TIMEOUT_CYCLES - 1)) && !ready_sel;

  always_ff @(posedge clk) begin
    if (reset || state != ACCESS) timer <= '0;
    else                          timer <= timer + 1'b1;
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      m_irq <= 1'b0;
    end else begin
      m_irq <= |s_irq;
      case (state)
        IDLE: begin
          if (m_valid) begin
            sel   <= dec_index;
            state <= dec_hit ? ACCESS : DECERR;
          end
        end
        ACCESS: begin
          if (!m_valid || ready_sel || abort) state <= IDLE;
        end
        DECERR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_valid = '0;
    m_ready = 1'b0;
    m_rdata = '0;
    err     = 1'b0;
    case (state)
      ACCESS: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (sel == IW'(i)) s_valid[i] = m_valid && !abort;
        end
        if (abort) begin
          m_ready = 1'b1;
          m_rdata = BUS_ERROR_WORD;
          err     = 1'b1;
        end else begin
          m_ready = ready_sel;
          m_rdata = rdata_sel;
        end
      end
      DECERR: begin
        m_ready = 1'b1;
        m_rdata = BUS_ERROR_WORD;
        err     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
